fifo_selftest_top: RTL and testbench



---
 rtl/fifo_demo_pkg.sv | 11 +
 rtl/sync_fifo.sv | 60 ++++++
 rtl/fifo_selftest_top.sv | 89 ++++++++
 tb/tb_fifo_selftest_top.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_demo_pkg.sv
// Shared parameters and controller state type for the FIFO self-test demo.
// Imported by the FIFO and the self-test top level.
package fifo_demo_pkg;
  localparam int DATA_W_DEF = 8;
  localparam int ADDR_W_DEF = 4;

  typedef enum logic {
    FILL  = 1'b0,
    DRAIN = 1'b1
  } state_t;
endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with extra-MSB pointers and a registered read port.
// Overflowing writes and underflowing reads are dropped.
module sync_fifo
  import fifo_demo_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              sysclk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              full,
  output logic              empty
);
  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [ADDR_W:0]   r_wr_ptr;
  logic [ADDR_W:0]   r_rd_ptr;
  logic [DATA_W-1:0] r_rd_data;

  logic              w_wr_ok;
  logic              w_rd_ok;
  logic [DATA_W-1:0] w_rd_word;

  assign empty = (r_wr_ptr == r_rd_ptr);
  assign full  = (r_wr_ptr[ADDR_W-1:0] == r_rd_ptr[ADDR_W-1:0])
              && (r_wr_ptr[ADDR_W] != r_rd_ptr[ADDR_W]);

  assign w_wr_ok   = wr_en && !full;
  assign w_rd_ok   = rd_en && !empty;
  assign w_rd_word = r_mem[r_rd_ptr[ADDR_W-1:0]];
  assign rd_data   = r_rd_data;

  // Storage has no reset; only the pointers define what is valid.
  always_ff @(posedge sysclk) begin
    if (w_wr_ok) begin
      r_mem[r_wr_ptr[ADDR_W-1:0]] <= wr_data;
    end
  end

  always_ff @(posedge sysclk) begin
    if (rst_n) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_rd_data <= '0;
    end else begin
      if (w_wr_ok) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_rd_ok) begin
        r_rd_ptr  <= r_rd_ptr + 1'b1;
        r_rd_data <= w_rd_word;
      end
    end
  end
endmodule

// File: rtl/fifo_selftest_top.sv
// FIFO exerciser: fill with a byte ramp, drain and check it, forever.
// rst_n is an active-high synchronous reset despite its name.
module fifo_selftest_top
  import fifo_demo_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              sysclk,
  input  logic              rst_n,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              err,
  output logic [15:0]       rounds
);
  state_t            r_state;
  logic [DATA_W-1:0] r_wr_cnt;
  logic [DATA_W-1:0] r_exp_cnt;
  logic              r_rd_valid;
  logic              r_err;
  logic [15:0]       r_rounds;

  logic              w_full;
  logic              w_empty;
  logic              w_wr_en;
  logic              w_rd_en;
  logic [DATA_W-1:0] w_rd_data;
  logic              w_mismatch;

  sync_fifo #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_fifo (
    .sysclk  (sysclk),
    .rst_n   (rst_n),
    .wr_en   (w_wr_en),
    .wr_data (r_wr_cnt),
    .rd_en   (w_rd_en),
    .rd_data (w_rd_data),
    .full    (w_full),
    .empty   (w_empty)
  );

  assign w_wr_en    = (r_state == FILL) && !w_full;
  assign w_rd_en    = (r_state == DRAIN) && !w_empty;
  assign w_mismatch = r_rd_valid && (w_rd_data != r_exp_cnt);

  // err flags the bad word in the same cycle it is presented.
  assign rd_data  = w_rd_data;
  assign rd_valid = r_rd_valid;
  assign err      = r_err | w_mismatch;
  assign rounds   = r_rounds;

  always_ff @(posedge sysclk) begin
    if (rst_n) begin
      r_state    <= FILL;
      r_wr_cnt   <= '0;
      r_exp_cnt  <= '0;
      r_rd_valid <= 1'b0;
      r_err      <= 1'b0;
      r_rounds   <= '0;
    end else begin
      r_rd_valid <= w_rd_en;
      if (w_wr_en) begin
        r_wr_cnt <= r_wr_cnt + 1'b1;
      end
      if (r_rd_valid) begin
        r_exp_cnt <= r_exp_cnt + 1'b1;
      end
      if (w_mismatch) begin
        r_err <= 1'b1;
      end
      unique case (r_state)
        FILL: begin
          if (w_full) begin
            r_state <= DRAIN;
          end
        end
        DRAIN: begin
          // Wait for the final word to be checked before refilling.
          if (w_empty && !r_rd_valid) begin
            r_state  <= FILL;
            r_rounds <= r_rounds + 16'd1;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_fifo_selftest_top.sv
// Bench for fifo_selftest_top and a standalone sync_fifo.
// Reads are scored against a running byte count; the FIFO against a queue.
module tb_fifo_selftest_top;
  import fifo_demo_pkg::*;

  localparam int DW    = 8;
  localparam int AW    = 4;
  localparam int DEPTH = 16;

  logic          sysclk = 1'b0;
  logic          rst_n  = 1'b1;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic          err;
  logic [15:0]   rounds;

  logic          ut_rst = 1'b1;
  logic          ut_we  = 1'b0;
  logic          ut_re  = 1'b0;
  logic [DW-1:0] ut_wd  = '0;
  logic [DW-1:0] ut_rd;
  logic          ut_full;
  logic          ut_empty;

  int n_cmp = 0;
  int n_bad = 0;

  always #10 sysclk = ~sysclk;

  fifo_selftest_top #(
    .DATA_W (DW),
    .ADDR_W (AW)
  ) dut (
    .sysclk   (sysclk),
    .rst_n    (rst_n),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .err      (err),
    .rounds   (rounds)
  );

  sync_fifo #(
    .DATA_W (DW),
    .ADDR_W (AW)
  ) u_ut (
    .sysclk  (sysclk),
    .rst_n   (ut_rst),
    .wr_en   (ut_we),
    .wr_data (ut_wd),
    .rd_en   (ut_re),
    .rd_data (ut_rd),
    .full    (ut_full),
    .empty   (ut_empty)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  // Read-stream reference: the n-th word after reset must be n mod 256.
  int          n_reads     = 0;
  logic [15:0] prev_rounds = '0;
  logic [7:0]  last_data   = '0;
  bit          have_last   = 0;
  bit          saw_wrap    = 0;
  bit          inj_mode    = 0;
  bit          seen_bad    = 0;
  logic [7:0]  e;

  always @(negedge sysclk) begin
    if (rst_n) begin
      n_reads     = 0;
      prev_rounds = '0;
      have_last   = 0;
      seen_bad    = 0;
    end else begin
      if (rd_valid) begin
        e = 8'(n_reads % 256);
        if (!inj_mode) begin
          check("rd_data", rd_data, e);
          check("err_ok", err, 0);
        end else if (rd_data != e) begin
          check("err_rise", err, 1);
          seen_bad = 1;
        end else begin
          check("err_hold", err, seen_bad);
        end
        if (have_last && last_data == 8'hFF && rd_data == 8'h00)
          saw_wrap = 1;
        last_data = rd_data;
        have_last = 1;
        n_reads++;
      end
      if (rounds != prev_rounds) begin
        check("rounds_step", rounds, n_reads / 16);
        prev_rounds = rounds;
      end
    end
  end

  // Queue reference for the standalone FIFO.
  logic [DW-1:0] ut_q[$];
  logic [DW-1:0] ut_exp = '0;

  task automatic ut_reset();
    ut_rst = 1'b1;
    @(posedge sysclk); #1;
    ut_rst = 1'b0;
    ut_q.delete();
    ut_exp = '0;
  endtask

  task automatic ut_op(input bit we, input logic [DW-1:0] wd, input bit re);
    bit dw;
    bit dr;
    ut_we = we;
    ut_wd = wd;
    ut_re = re;
    dw = we && (ut_q.size() < DEPTH);
    dr = re && (ut_q.size() > 0);
    if (dr) ut_exp = ut_q.pop_front();
    if (dw) ut_q.push_back(wd);
    @(posedge sysclk); #1;
    ut_we = 1'b0;
    ut_re = 1'b0;
    check("ut_rd", ut_rd, ut_exp);
    check("ut_full", ut_full, ut_q.size() == DEPTH);
    check("ut_empty", ut_empty, ut_q.size() == 0);
  endtask

  task automatic ut_drain(output int n);
    n = 0;
    while (!ut_empty && n < 40) begin
      ut_op(0, '0, 1);
      n++;
    end
  endtask

  logic [7:0] bad;

  initial begin
    int  nw;
    int  cnt;
    int  off;
    bit  hit;
    logic [7:0] held;

    // Reset held for 5 cycles
    rst_n = 1'b1;
    repeat (5) @(posedge sysclk);
    @(negedge sysclk);
    check("rst_err", err, 0);
    check("rst_rounds", rounds, 0);
    check("rst_valid", rd_valid, 0);
    check("rst_rdata", rd_data, 0);
    check("rst_empty", dut.w_empty, 1);

    // First round
    @(posedge sysclk); #1;
    rst_n = 1'b0;
    nw  = 0;
    hit = 0;
    for (int t = 0; t < 40 && !hit; t++) begin
      @(negedge sysclk);
      if (dut.w_wr_en) begin
        check("wr_data", dut.r_wr_cnt, nw);
        nw++;
      end
      if (dut.w_full) hit = 1;
    end
    check("full_seen", hit, 1);
    check("fill_count", nw, 16);
    hit = 0;
    for (int t = 0; t < 40 && !hit; t++) begin
      @(negedge sysclk);
      if (rounds == 16'd1) hit = 1;
    end
    check("round1_seen", hit, 1);
    check("round1_reads", n_reads, 16);
    check("round1_empty", dut.w_empty, 1);
    check("round1_err", err, 0);

    // Long run across many pattern wraps
    repeat (50000) @(posedge sysclk);
    @(negedge sysclk);
    check("rounds_min", rounds >= 16'd1300, 1);
    check("long_err", err, 0);
    check("wrap_seen", saw_wrap, 1);

    // Corrupt one word as it leaves memory during DRAIN
    hit = 0;
    for (int t = 0; t < 60 && !hit; t++) begin
      @(negedge sysclk);
      if (dut.r_state == DRAIN) hit = 1;
    end
    check("drain_seen", hit, 1);
    off = $urandom_range(10, 2);
    repeat (off) @(negedge sysclk);
    check("inj_rd_en", dut.w_rd_en, 1);
    inj_mode = 1;
    bad = ~dut.u_fifo.w_rd_word;
    force dut.u_fifo.w_rd_word = bad;
    @(posedge sysclk); #1;
    release dut.u_fifo.w_rd_word;
    @(negedge sysclk);
    check("inj_valid", rd_valid, 1);
    check("inj_err", err, 1);
    repeat (60) @(posedge sysclk);
    for (int i = 0; i < 3; i++) begin
      @(negedge sysclk);
      check("err_sticky", err, 1);
    end
    check("bad_seen", seen_bad, 1);

    @(posedge sysclk); #1;
    rst_n    = 1'b1;
    inj_mode = 0;
    repeat (2) @(posedge sysclk);
    @(negedge sysclk);
    check("err_clear", err, 0);
    @(posedge sysclk); #1;
    rst_n = 1'b0;

    // Reset after 5 reads of a drain
    hit = 0;
    for (int t = 0; t < 80 && !hit; t++) begin
      @(negedge sysclk);
      if (n_reads == 5) hit = 1;
    end
    check("five_reads", hit, 1);
    @(posedge sysclk); #1;
    rst_n = 1'b1;
    @(posedge sysclk);
    @(negedge sysclk);
    check("mid_valid", rd_valid, 0);
    check("mid_rdata", rd_data, 0);
    check("mid_err", err, 0);
    check("mid_rounds", rounds, 0);
    check("mid_empty", dut.w_empty, 1);
    check("mid_state", dut.r_state, FILL);
    check("mid_wrcnt", dut.r_wr_cnt, 0);
    @(posedge sysclk); #1;
    rst_n = 1'b0;
    hit = 0;
    for (int t = 0; t < 60 && !hit; t++) begin
      @(negedge sysclk);
      if (rounds == 16'd1) hit = 1;
    end
    check("restart_round", hit, 1);
    check("restart_reads", n_reads, 16);
    check("restart_err", err, 0);

    // Standalone FIFO boundaries
    ut_reset();
    check("ut_rst_empty", ut_empty, 1);
    for (int i = 0; i < DEPTH + 1; i++)
      ut_op(1, 8'($urandom), 0);
    ut_drain(cnt);
    check("ut_full_count", cnt, 16);

    held = ut_rd;
    ut_op(0, '0, 1);
    check("ut_empty_hold", ut_rd, held);

    ut_reset();
    for (int i = 0; i < 8; i++)
      ut_op(1, 8'($urandom), 0);
    for (int i = 0; i < 5; i++)
      ut_op(1, 8'($urandom), 1);
    ut_drain(cnt);
    check("ut_rw_count", cnt, 8);

    ut_reset();
    for (int i = 0; i < 300; i++)
      ut_op(bit'($urandom_range(1, 0)), 8'($urandom),
            bit'($urandom_range(1, 0)));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
